pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Freezes stages while
//  data memory is busy (mem_ready handshake), inserts a bubble on load-use hazards and
//  flushes IF/ID, ID/EX on taken branches. Drives stage-register enables/flushes and the
//  MEM/WB bubble (forces RegWrite=0 into WB). Memory-wait watchdog raises sticky mem_err.
// PARAMETERS
//  TIMEOUT  255  max cycles in MEM_WAIT before error; must be < 2**CNT_W
//  CNT_W    8    width of wait counter
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   synchronous, active-low reset
//  mem_req       in   1   EX/MEM holds load or store (MemRead|MemWrite)
//  mem_ready     in   1   data memory completed access this cycle
//  idex_MemRead  in   1   instruction in EX is a load
//  idex_Rt       in   5   load destination in EX
//  ifid_Rs       in   5   source Rs of instruction in ID
//  ifid_Rt       in   5   source Rt of instruction in ID
//  branch_taken  in   1   branch/jump resolved taken in EX
//  pc_en, ifid_en, idex_en, exmem_en  out 1 each  stage-register load enables
//  ifid_flush, idex_flush             out 1 each  clear stage register to NOP
//  memwb_bubble  out  1   MEM/WB captures RegWrite=0, MemtoReg=0
//  mem_err       out  1   sticky watchdog error
//  stall_cycles  out  32  cycles with pc_en=0 (feature)
//  flush_count   out  32  taken-branch flushes (feature)
// BEHAVIOUR
//  - Reset: clk and reset are the only timing inputs; reset sampled low -> state=RUN,
//    wait_cnt=0, mem_err=0, counters=0. While reset is low all enables=0, flushes=0,
//    memwb_bubble=1.
//  - Outputs are combinational from registered state + current inputs (0-cycle latency).
//  - States: RUN, MEM_WAIT, ERROR.
//  - RUN, priority high->low:
//    1 mem_req & !mem_ready: all enables=0, memwb_bubble=1, flushes=0; next MEM_WAIT,
//      wait_cnt<=1.
//    2 branch_taken: all enables=1, ifid_flush=1, idex_flush=1.
//    3 load-use (idex_MemRead & idex_Rt!=0 & (idex_Rt==ifid_Rs | idex_Rt==ifid_Rt)):
//      pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1, memwb_bubble=0.
//    4 else: all enables=1, flushes=0, memwb_bubble=0.
//  - MEM_WAIT: mem_ready=1 or mem_req=0 -> outputs as RUN case 2-4 (pipeline advances
//    this cycle), next RUN, wait_cnt<=0. Else all enables=0, memwb_bubble=1,
//    branch/load-use ignored (held stages re-evaluated after release); wait_cnt+1;
//    if wait_cnt==TIMEOUT -> next ERROR. mem_ready in the TIMEOUT cycle wins (no error).
//  - ERROR: all enables=0, flushes=0, memwb_bubble=1, mem_err=1; exits only by reset.
//  - Reset low mid-wait: abandons access, returns to RUN next cycle; no partial output.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_cycles +1 each non-reset cycle with pc_en=0; flush_count
//  +1 each cycle with ifid_flush=1; both saturate at 32'hFFFF_FFFF, cleared by reset.
//  Not defined: ports exist, tied to 32'h0, no counter flops.
// TESTING
//  - mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, bubble=1,
//    4th cycle all enables=1, state RUN; stall_cycles=3 (with STALL_CNT_EN).
//  - idex_MemRead=1, idex_Rt=5, ifid_Rs=5 -> pc_en=0, ifid_en=0, idex_flush=1; with
//    idex_Rt=0 -> no stall.
//  - branch_taken=1 and load-use same cycle -> ifid_flush=idex_flush=1, pc_en=1;
//    flush_count=1.
//  - mem_req=1, mem_ready=0 held, TIMEOUT=4 -> mem_err=1 after 5th stall cycle, stays 1
//    with mem_ready=1; cleared only by reset=0.
//  - mem_ready rises exactly when wait_cnt==TIMEOUT -> no error, RUN next cycle.
//  - reset=0 during MEM_WAIT -> enables=0, bubble=1; after release state RUN, counters 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/handshake bundle between the pipeline datapath and its stall/flush sequencer.
// master = sequencer side (drives enables/flushes), slave = datapath side.
interface pipeline_stall_ctrl_if;
   logic        mem_req;
   logic        mem_ready;
   logic        idex_mem_read;
   logic [4:0]  idex_rt;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        branch_taken;
   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        memwb_bubble;
   logic        mem_err;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   modport master (
      input  mem_req, mem_ready, idex_mem_read, idex_rt, ifid_rs, ifid_rt, branch_taken,
      output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble,
             mem_err, stall_cycles, flush_count
   );

   modport slave (
      output mem_req, mem_ready, idex_mem_read, idex_rt, ifid_rs, ifid_rt, branch_taken,
      input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble,
             mem_err, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, load-use bubble,
// branch flush and memory watchdog. Define STALL_CNT_EN to build the stall/flush counters.
module pipeline_stall_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_stall_ctrl_if.master ctrl
);

   typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

   state_e           r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_mem_err;

   logic w_mem_stall;
   logic w_load_use;
   logic w_hold;
   logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
   logic w_ifid_flush, w_idex_flush, w_bubble;

   assign w_mem_stall = ctrl.mem_req & ~ctrl.mem_ready;
   assign w_load_use  = ctrl.idex_mem_read & (ctrl.idex_rt != 5'd0) &
                        ((ctrl.idex_rt == ctrl.ifid_rs) | (ctrl.idex_rt == ctrl.ifid_rt));

   // Release from MEM_WAIT uses the same condition as entry, so one hold term covers both
   assign w_hold = (r_state == StError) | w_mem_stall;

   always_comb begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_exmem_en   = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_bubble     = 1'b1;
      if (reset && !w_hold) begin
         w_bubble = 1'b0;
         if (ctrl.branch_taken) begin
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
         end else if (w_load_use) begin
            w_idex_en    = 1'b1;
            w_exmem_en   = 1'b1;
            w_idex_flush = 1'b1;
         end else begin
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= StRun;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         unique case (r_state)
            StRun: begin
               if (w_mem_stall) begin
                  r_state    <= StMemWait;
                  r_wait_cnt <= CNT_W'(1);
               end
            end
            StMemWait: begin
               if (!w_mem_stall) begin
                  r_state    <= StRun;
                  r_wait_cnt <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                  if (r_wait_cnt == CNT_W'(TIMEOUT)) begin
                     r_state   <= StError;
                     r_mem_err <= 1'b1;
                  end
               end
            end
            StError: r_mem_err <= 1'b1;
            default: r_state <= StRun;
         endcase
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (!w_pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (w_ifid_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
            r_flush_count <= r_flush_count + 32'd1;
         end
      end
   end

   assign ctrl.stall_cycles = r_stall_cycles;
   assign ctrl.flush_count  = r_flush_count;
`else
   assign ctrl.stall_cycles = 32'h0;
   assign ctrl.flush_count  = 32'h0;
`endif

   assign ctrl.pc_en        = w_pc_en;
   assign ctrl.ifid_en      = w_ifid_en;
   assign ctrl.idex_en      = w_idex_en;
   assign ctrl.exmem_en     = w_exmem_en;
   assign ctrl.ifid_flush   = w_ifid_flush;
   assign ctrl.idex_flush   = w_idex_flush;
   assign ctrl.memwb_bubble = w_bubble;
   assign ctrl.mem_err      = r_mem_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: per-cycle reference model plus directed literal checks.
module tb_pipeline_stall_ctrl;

   localparam int unsigned TIMEOUT = 4;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   pipeline_stall_ctrl_if bus ();

   pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
   localparam logic [6:0] Frozen  = 7'b0000001;
   localparam logic [6:0] Flow    = 7'b1111000;
   localparam logic [6:0] Branch  = 7'b1111110;
   localparam logic [6:0] LoadUse = 7'b0011010;

   function automatic logic [6:0] got_vec();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
              bus.ifid_flush, bus.idex_flush, bus.memwb_bubble};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: counts consecutive stalled memory cycles rather than states.
   bit          m_err;
   int unsigned m_wait;
   logic [31:0] m_stall;
   logic [31:0] m_flush;

   initial begin
      m_err = 0; m_wait = 0; m_stall = '0; m_flush = '0;
   end

   always @(negedge clk) begin
      logic [6:0] e;
      if (!reset || m_err || (bus.mem_req && !bus.mem_ready)) e = Frozen;
      else if (bus.branch_taken) e = Branch;
      else if (bus.idex_mem_read && bus.idex_rt != 0 &&
               (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt)) e = LoadUse;
      else e = Flow;
      chk("model_outputs", {25'd0, got_vec()}, {25'd0, e});
      if (reset) begin
         chk("model_mem_err", {31'd0, bus.mem_err}, {31'd0, m_err});
         chk("model_stall_cycles", bus.stall_cycles, m_stall);
         chk("model_flush_count", bus.flush_count, m_flush);
      end
      if (!reset) begin
         m_err = 0; m_wait = 0; m_stall = '0; m_flush = '0;
      end else begin
`ifdef STALL_CNT_EN
         if (!e[6] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (e[2] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
`endif
         if (!m_err) begin
            if (bus.mem_req && !bus.mem_ready) begin
               m_wait++;
               if (m_wait == TIMEOUT + 1) m_err = 1;
            end else begin
               m_wait = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic req, input logic rdy, input logic mr, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rt2, input logic br);
      bus.mem_req = req; bus.mem_ready = rdy; bus.idex_mem_read = mr;
      bus.idex_rt = rt; bus.ifid_rs = rs; bus.ifid_rt = rt2; bus.branch_taken = br;
      #1;
   endtask

   logic [31:0] exp_cnt;

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("reset_outputs", {25'd0, got_vec()}, {25'd0, Frozen});
      tick(); tick();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("idle_flow", {25'd0, got_vec()}, {25'd0, Flow});
      chk("reset_mem_err", {31'd0, bus.mem_err}, 32'd0);
      tick();

      // Three-cycle memory wait then completion
      set_in(1, 0, 0, 0, 0, 0, 0);
      chk("mem_wait_frozen", {25'd0, got_vec()}, {25'd0, Frozen});
      repeat (3) tick();
      set_in(1, 1, 0, 0, 0, 0, 0);
      chk("mem_done_flow", {25'd0, got_vec()}, {25'd0, Flow});
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
`ifdef STALL_CNT_EN
      exp_cnt = 32'd3;
`else
      exp_cnt = 32'd0;
`endif
      chk("stall_cycles_3", bus.stall_cycles, exp_cnt);

      // Load-use on Rs, then Rt=0 never stalls
      set_in(0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
      chk("load_use_stall", {25'd0, got_vec()}, {25'd0, LoadUse});
      tick();
      set_in(0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
      chk("load_use_rt0", {25'd0, got_vec()}, {25'd0, Flow});
      tick();

      // Branch beats load-use
      set_in(0, 0, 1, 5'd5, 5'd5, 5'd0, 1);
      chk("branch_over_lu", {25'd0, got_vec()}, {25'd0, Branch});
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
`ifdef STALL_CNT_EN
      exp_cnt = 32'd1;
`else
      exp_cnt = 32'd0;
`endif
      chk("flush_count_1", bus.flush_count, exp_cnt);

      // mem_ready arrives exactly at the watchdog limit
      set_in(1, 0, 0, 0, 0, 0, 0);
      repeat (TIMEOUT) tick();
      set_in(1, 1, 0, 0, 0, 0, 0);
      chk("edge_release", {25'd0, got_vec()}, {25'd0, Flow});
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("edge_no_err", {31'd0, bus.mem_err}, 32'd0);
      chk("edge_run", {25'd0, got_vec()}, {25'd0, Flow});
      tick();

      // Watchdog expiry is sticky
      set_in(1, 0, 0, 0, 0, 0, 0);
      repeat (TIMEOUT + 1) tick();
      chk("timeout_err", {31'd0, bus.mem_err}, 32'd1);
      set_in(1, 1, 0, 0, 0, 0, 0);
      chk("err_frozen", {25'd0, got_vec()}, {25'd0, Frozen});
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1);
      chk("err_sticky", {31'd0, bus.mem_err}, 32'd1);
      chk("err_ignores_branch", {25'd0, got_vec()}, {25'd0, Frozen});
      reset = 1'b0;
      #1;
      chk("reset_in_err", {25'd0, got_vec()}, {25'd0, Frozen});
      tick();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("err_cleared", {31'd0, bus.mem_err}, 32'd0);
      chk("stall_cleared", bus.stall_cycles, 32'd0);
      chk("flush_cleared", bus.flush_count, 32'd0);
      tick();

      // Reset in the middle of a memory wait
      set_in(1, 0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      reset = 1'b0;
      #1;
      chk("reset_mid_wait", {25'd0, got_vec()}, {25'd0, Frozen});
      tick();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("after_reset_run", {25'd0, got_vec()}, {25'd0, Flow});
      chk("after_reset_cnt", bus.stall_cycles, 32'd0);
      tick();

      // Mixed traffic, checked by the model only
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 63) != 0);
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0));
         tick();
      end
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
